pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : In-order pipeline scoreboard with forwarding-select and load-use
//            stall generation. Optional perf counters via PIPE_HAZARD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int STAGES   = 3,
    parameter int REG_AW   = 5,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    localparam int SW      = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [REG_AW-1:0]        issue_rs,
    input  logic [REG_AW-1:0]        issue_rt,
    input  logic [REG_AW-1:0]        issue_rd,
    input  logic                     issue_we,
    input  logic                     issue_is_load,
    input  logic                     flush_i,
    output logic                     stall_o,
    output logic [SW-1:0]            fwd_rs_sel,
    output logic [SW-1:0]            fwd_rt_sel,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*REG_AW-1:0] stage_rd,
    output logic [STAGES-1:0]        stage_we
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              fwd_cnt
`endif
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] we_q;
    logic [STAGES-1:0] ld_q;
    logic [REG_AW-1:0] rd_q [STAGES];

    logic [SW-1:0] w_rs_sel;
    logic [SW-1:0] w_rt_sel;
    logic          w_rs_blk;
    logic          w_rt_blk;
    logic          w_stall;
    logic          w_load_s0;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        w_rs_sel = '0;
        w_rt_sel = '0;
        w_rs_blk = 1'b0;
        w_rt_blk = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (valid_q[k] && we_q[k] && (rd_q[k] != '0)) begin
                if (rd_q[k] == issue_rs) begin
                    if (k >= (ld_q[k] ? LOAD_LAT : ALU_LAT)) begin
                        w_rs_sel = SW'(k + 1);
                        w_rs_blk = 1'b0;
                    end else begin
                        w_rs_sel = '0;
                        w_rs_blk = 1'b1;
                    end
                end
                if (rd_q[k] == issue_rt) begin
                    if (k >= (ld_q[k] ? LOAD_LAT : ALU_LAT)) begin
                        w_rt_sel = SW'(k + 1);
                        w_rt_blk = 1'b0;
                    end else begin
                        w_rt_sel = '0;
                        w_rt_blk = 1'b1;
                    end
                end
            end
        end
    end

    assign w_stall    = issue_valid && !flush_i && (w_rs_blk || w_rt_blk);
    assign w_load_s0  = issue_valid && !w_stall && !flush_i;
    assign stall_o    = w_stall;
    assign fwd_rs_sel = issue_valid ? w_rs_sel : '0;
    assign fwd_rt_sel = issue_valid ? w_rt_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            we_q    <= '0;
            ld_q    <= '0;
        end else begin
            valid_q[0] <= w_load_s0;
            we_q[0]    <= issue_we;
            ld_q[0]    <= issue_is_load;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                we_q[k]    <= we_q[k-1];
                ld_q[k]    <= ld_q[k-1];
            end
        end
    end

    // Destinations need no reset; every consumer qualifies them with valid.
    always_ff @(posedge clk) begin
        rd_q[0] <= issue_rd;
        for (int k = 1; k < STAGES; k++) begin
            rd_q[k] <= rd_q[k-1];
        end
    end

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_stage_out
            assign stage_rd[g*REG_AW +: REG_AW] = rd_q[g];
        end
    endgenerate

    assign stage_valid = valid_q;
    assign stage_we    = we_q & valid_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic        w_fwd_evt;

    assign w_fwd_evt = w_load_s0 && ((w_rs_sel != '0) || (w_rt_sel != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (w_fwd_evt && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl (3 stages).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int STAGES = 3;
    localparam int REG_AW = 5;
    localparam int SW     = 2;

    logic                     clk;
    logic                     rst;
    logic                     issue_valid;
    logic [REG_AW-1:0]        issue_rs;
    logic [REG_AW-1:0]        issue_rt;
    logic [REG_AW-1:0]        issue_rd;
    logic                     issue_we;
    logic                     issue_is_load;
    logic                     flush_i;
    logic                     stall_o;
    logic [SW-1:0]            fwd_rs_sel;
    logic [SW-1:0]            fwd_rt_sel;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*REG_AW-1:0] stage_rd;
    logic [STAGES-1:0]        stage_we;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0]              stall_cnt;
    logic [31:0]              fwd_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(
        .STAGES   (STAGES),
        .REG_AW   (REG_AW),
        .ALU_LAT  (0),
        .LOAD_LAT (1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_rd      (issue_rd),
        .issue_we      (issue_we),
        .issue_is_load (issue_is_load),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .fwd_rs_sel    (fwd_rs_sel),
        .fwd_rt_sel    (fwd_rt_sel),
        .stage_valid   (stage_valid),
        .stage_rd      (stage_rd),
        .stage_we      (stage_we)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cnt     (stall_cnt),
        .fwd_cnt       (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic we, input logic ld,
                         input logic fl);
        issue_valid   = v;
        issue_rs      = rs;
        issue_rt      = rt;
        issue_rd      = rd;
        issue_we      = we;
        issue_is_load = ld;
        flush_i       = fl;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (stage_valid !== 3'b000) begin n_bad++; $display("FAIL reset_valid: got %b want 000", stage_valid); end
        n_cmp++; if (stage_we !== 3'b000) begin n_bad++; $display("FAIL reset_we: got %b want 000", stage_we); end
        drive(1'b1, 5'd8, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        n_cmp++; if ({fwd_rs_sel, fwd_rt_sel} !== 4'b0000) begin n_bad++; $display("FAIL reset_sel: got %b/%b want 0/0", fwd_rs_sel, fwd_rt_sel); end
    endtask

    task automatic test_alu_fwd();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++; if (stage_we !== 3'b001) begin n_bad++; $display("FAIL alu_stage_we: got %b want 001", stage_we); end
        n_cmp++; if (stage_rd[4:0] !== 5'd8) begin n_bad++; $display("FAIL alu_stage_rd0: got %0d want 8", stage_rd[4:0]); end
        drive(1'b1, 5'd8, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fwd_rs_sel !== 2'd1) begin n_bad++; $display("FAIL alu_rs_sel: got %0d want 1", fwd_rs_sel); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %b want 0", stall_o); end
        n_cmp++; if (fwd_rt_sel !== 2'd0) begin n_bad++; $display("FAIL alu_rt_sel: got %0d want 0", fwd_rt_sel); end
        drive(1'b0, 5'd8, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
        n_cmp++; if ({stall_o, fwd_rs_sel} !== 3'b000) begin n_bad++; $display("FAIL idle_sel: got %b/%0d want 0/0", stall_o, fwd_rs_sel); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall_o); end
        tick();
        n_cmp++; if (stage_valid !== 3'b010) begin n_bad++; $display("FAIL lu_bubble: got %b want 010", stage_valid); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL lu_release: got %b want 0", stall_o); end
        n_cmp++; if (fwd_rs_sel !== 2'd2) begin n_bad++; $display("FAIL lu_rs_sel: got %0d want 2", fwd_rs_sel); end
        tick();
        n_cmp++; if (stage_valid !== 3'b101) begin n_bad++; $display("FAIL lu_advance: got %b want 101", stage_valid); end
        // rt side: load rd=7 blocks through rt alone
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL lu_rt_stall: got %b want 1", stall_o); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if ({fwd_rs_sel, fwd_rt_sel} !== 4'b0000) begin n_bad++; $display("FAIL zero_sel: got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL zero_stall: got %b want 0", stall_o); end
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd10, 5'd3, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fwd_rt_sel !== 2'd1) begin n_bad++; $display("FAIL young_rt_k0: got %0d want 1", fwd_rt_sel); end
        tick();
        n_cmp++; if (fwd_rt_sel !== 2'd2) begin n_bad++; $display("FAIL young_rt_k1: got %0d want 2", fwd_rt_sel); end
        drive(1'b0, 5'd0, 5'd10, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd10, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (fwd_rt_sel !== 2'd0) begin n_bad++; $display("FAIL young_rt_retired: got %0d want 0", fwd_rt_sel); end
        // Younger load shadows an older forwardable ALU result.
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL young_load_blocks: got %b want 1", stall_o); end
        // Younger ALU shadows an older load that is still in stage 0's wake.
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if ({stall_o, fwd_rs_sel} !== 3'b001) begin n_bad++; $display("FAIL young_alu_fwd: got %b/%0d want 0/1", stall_o, fwd_rs_sel); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stall_o); end
        tick();
        n_cmp++; if (stage_valid !== 3'b010) begin n_bad++; $display("FAIL flush_valid: got %b want 010", stage_valid); end
    endtask

    task automatic test_rst_mid_stall();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL rst_pre_stall: got %b want 1", stall_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_drop_stall: got %b want 0", stall_o); end
        n_cmp++; if (stage_valid !== 3'b000) begin n_bad++; $display("FAIL rst_drop_valid: got %b want 000", stage_valid); end
    endtask

`ifdef PIPE_HAZARD_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b1, 5'd9, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
            tick();
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (stall_cnt !== 32'd3) begin n_bad++; $display("FAIL perf_stall_cnt: got %0d want 3", stall_cnt); end
        n_cmp++; if (fwd_cnt !== 32'd3) begin n_bad++; $display("FAIL perf_fwd_cnt: got %0d want 3", fwd_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({stall_cnt, fwd_cnt} !== 64'd0) begin n_bad++; $display("FAIL perf_rst: got %0d/%0d want 0/0", stall_cnt, fwd_cnt); end
        n_cmp++; if (stage_valid !== 3'b000) begin n_bad++; $display("FAIL perf_rst_valid: got %b want 000", stage_valid); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_zero_reg();
        test_youngest();
        test_flush();
        test_rst_mid_stall();
`ifdef PIPE_HAZARD_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
